mont_multicore_ctrl: RTL and testbench
======================================

# mont_multicore_ctrl

Command sequencer between the ARM command/data port and `NUM_CORES` Montgomery multiplier cores. Generalises the single-core wrapper's command set with a parameterised operand width and core count, masked parallel launch across cores, per-core result readback and an illegal-opcode flag. Sits inside `rsa_wrapper`, directly behind the ARM handshake ports and in front of the core array.

## Interface
- `DATA_W`, 1024, operand/result width in bits
- `NUM_CORES`, 2, number of attached Montgomery cores (1..8)
- `TIMEOUT_CYCLES`, 4096, compute watchdog limit (used only with `MONT_CTRL_TIMEOUT_EN`)

- `clk` in 1: single clock, all logic rising-edge
- `resetn` in 1: asynchronous, active-low reset
- `arm_to_fpga_cmd` in 32: `[3:0]` opcode, `[15:8]` core mask, `[23:16]` core index
- `arm_to_fpga_cmd_valid` in 1: command strobe
- `fpga_to_arm_done` out 1: command complete, held until read
- `fpga_to_arm_done_read` in 1: done acknowledge
- `arm_to_fpga_data_valid` in 1, `arm_to_fpga_data_ready` out 1, `arm_to_fpga_data` in DATA_W: inbound operand
- `fpga_to_arm_data_valid` out 1, `fpga_to_arm_data_ready` in 1, `fpga_to_arm_data` out DATA_W: outbound result
- `core_op_ab` out DATA_W, `core_op_m` out DATA_W: operand registers, broadcast to all cores
- `core_start` out NUM_CORES: one-cycle start pulse per core
- `core_done` in NUM_CORES: per-core completion pulse or level
- `core_result` in NUM_CORES*DATA_W: core i result at `[i*DATA_W +: DATA_W]`
- `leds` out 4: `[0]` busy, `[1]` illegal cmd, `[2]` computing, `[3]` timeout

## Operation
- FSM states: IDLE, RX_AB, RX_M, START, COMPUTE, TX, DONE.
- IDLE: command accepted when `arm_to_fpga_cmd_valid`=1. Opcode 1 -> RX_AB; 2 -> RX_M; 4 -> START; 5 -> TX. Opcodes 0, 3, 6–15 are reserved for the exponentiation sequencer: go to DONE with `leds[1]`=1.
- `leds[1]` clears on the next legal command.
- Commands arriving outside IDLE are ignored. No queueing.
- RX_AB / RX_M: `arm_to_fpga_data_ready`=1. On `valid&&ready`, latch into `core_op_ab` / `core_op_m`, then go to DONE.
- START: latch `mask = cmd[8 +: NUM_CORES]`; mask bits at or above NUM_CORES are discarded. Pulse `core_start` = mask for exactly one cycle, clear the per-core sticky done flags, then go to COMPUTE.
  - Mask == 0: go straight to DONE, no pulse.
- COMPUTE: sticky `flag[i]` is set on `core_done[i]`. When `(flag & mask) == mask`, go to DONE. Done from unmasked cores is ignored.
- TX: `fpga_to_arm_data_valid`=1 with `core_result` of the selected core index, held stable. On `valid&&ready`, go to DONE.
  - Index ≥ NUM_CORES: data = 0.
- DONE: `fpga_to_arm_done`=1 until `fpga_to_arm_done_read`=1, then go to IDLE.
- Operand registers persist across commands. Only reset or a new RX command changes them.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - operand registers 0
  - flags and mask 0
- Command acceptance → first cycle of the next state: 1 clock.
- `arm_to_fpga_data_ready` rises 1 cycle after command acceptance.
- The transfer cycle is the last cycle with ready=1. `fpga_to_arm_done` rises the next cycle.
- The `core_start` pulse occurs in the cycle after acceptance.
- `core_done` is sampled from the cycle after the pulse. A `core_done` in the pulse cycle itself is ignored.
- Completion: the cycle after the last masked flag sets, state is DONE.
- If `done_read` is already high on DONE entry: done is high for exactly 1 cycle, and IDLE follows.
- Outputs are registered. `fpga_to_arm_data` is stable while valid=1.
- Reset asserted mid-operation: immediate return to IDLE. An in-flight start pulse, ready, valid and done all drop asynchronously.

## Configuration
- `MONT_CTRL_TIMEOUT_EN` defined:
  - COMPUTE counts cycles.
  - On reaching `TIMEOUT_CYCLES`, go to DONE with `leds[3]`=1.
  - `leds[3]` clears on the next START.
- Undefined:
  - no counter
  - COMPUTE waits indefinitely
  - `leds[3]` is tied to 0

## Test plan
- Cmd 0x1 with data 0x1234, then cmd 0x2 with data 0xF00D → `core_op_ab`=0x1234 and `core_op_m`=0xF00D; done asserted once per command.
- Cmd 0x0304 (mask 0b11): core0 done after 10 cycles, core1 after 25 → `core_start`=0b11 for 1 cycle; done rises exactly 1 cycle after core1's done.
- Cmd 0x00010005 with `core_result[1]`=0xABCD → `fpga_to_arm_data`=0xABCD; valid held until ready; done follows.
- Cmd 0x7 → no data handshake; immediate done with `leds[1]`=1. A following cmd 0x1 clears `leds[1]`.
- Cmd 0x0104 with core0 never done:
  - with the macro and `TIMEOUT_CYCLES`=16 → done after 16 cycles, `leds[3]`=1
  - without the macro → no done
- `resetn` low during COMPUTE → all outputs 0 and state IDLE; a following cmd 0x1 works normally.

Source files
------------

// File: rtl/mont_multicore_ctrl.sv
// -----------------------------------------------------------------------------
// mont_multicore_ctrl
//
// Command sequencer between the ARM command/data port and NUM_CORES Montgomery
// multiplier cores. It loads the shared operand registers, launches a masked
// subset of cores in parallel, and waits until every launched core has reported
// done. It also reads back one core's result and flags reserved opcodes.
//
// Optional feature macro: MONT_CTRL_TIMEOUT_EN
//   defined   -> COMPUTE has a TIMEOUT_CYCLES watchdog, leds[3] = timeout
//   undefined -> COMPUTE waits indefinitely, leds[3] tied to 0
//
// Ports
//   clk, resetn                : clock, asynchronous active-low reset
//   arm_to_fpga_cmd[_valid]    : [3:0] opcode, [15:8] core mask, [23:16] index
//   fpga_to_arm_done[_read]    : completion flag, held until acknowledged
//   arm_to_fpga_data*          : inbound operand handshake (valid/ready)
//   fpga_to_arm_data*          : outbound result handshake (valid/ready)
//   core_op_ab, core_op_m      : operand registers broadcast to all cores
//   core_start                 : one-cycle start pulse per core
//   core_done                  : per-core completion (pulse or level)
//   core_result                : core i result at [i*DATA_W +: DATA_W]
//   leds                       : [0] busy [1] illegal [2] computing [3] timeout
// -----------------------------------------------------------------------------
module mont_multicore_ctrl #(
    parameter int DATA_W         = 1024,
    parameter int NUM_CORES      = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [31:0]                 arm_to_fpga_cmd,
    input  logic                        arm_to_fpga_cmd_valid,
    output logic                        fpga_to_arm_done,
    input  logic                        fpga_to_arm_done_read,
    input  logic                        arm_to_fpga_data_valid,
    output logic                        arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0]           arm_to_fpga_data,
    output logic                        fpga_to_arm_data_valid,
    input  logic                        fpga_to_arm_data_ready,
    output logic [DATA_W-1:0]           fpga_to_arm_data,
    output logic [DATA_W-1:0]           core_op_ab,
    output logic [DATA_W-1:0]           core_op_m,
    output logic [NUM_CORES-1:0]        core_start,
    input  logic [NUM_CORES-1:0]        core_done,
    input  logic [NUM_CORES*DATA_W-1:0] core_result,
    output logic [3:0]                  leds
);

    typedef enum logic [2:0] {
        IDLE, RX_AB, RX_M, START, COMPUTE, TX, DONE
    } state_t;

    localparam logic [3:0] OP_RX_AB = 4'd1;
    localparam logic [3:0] OP_RX_M  = 4'd2;
    localparam logic [3:0] OP_START = 4'd4;
    localparam logic [3:0] OP_TX    = 4'd5;

    state_t               state;
    logic [NUM_CORES-1:0] mask;
    logic [NUM_CORES-1:0] flag;
    logic                 busy;
    logic                 illegal;
    logic                 computing;
    logic                 timeout;

    // Command field decode
    logic [3:0]           opcode;
    logic [NUM_CORES-1:0] cmd_mask;
    logic [7:0]           cmd_idx;
    logic                 unused_cmd;

    assign opcode     = arm_to_fpga_cmd[3:0];
    assign cmd_mask   = arm_to_fpga_cmd[8 +: NUM_CORES];  // bits >= NUM_CORES dropped
    assign cmd_idx    = arm_to_fpga_cmd[23:16];
    assign unused_cmd = ^{arm_to_fpga_cmd[31:24], arm_to_fpga_cmd[15:8],
                          arm_to_fpga_cmd[7:4]};

    // Result mux; an out-of-range index reads as zero.
    logic [DATA_W-1:0] sel_result;
    always_comb begin
        sel_result = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (cmd_idx == 8'(i)) sel_result = core_result[i*DATA_W +: DATA_W];
        end
    end

    // Completion looks at this cycle's core_done too, so DONE is entered the
    // cycle right after the last masked core reports.
    logic [NUM_CORES-1:0] flag_next;
    logic                 all_done;
    assign flag_next = flag | (core_done & mask);
    assign all_done  = ((flag_next & mask) == mask);

    assign leds = {timeout, computing, illegal, busy};

`ifdef MONT_CTRL_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state                  <= IDLE;
            mask                   <= '0;
            flag                   <= '0;
            busy                   <= 1'b0;
            illegal                <= 1'b0;
            computing              <= 1'b0;
            fpga_to_arm_done       <= 1'b0;
            arm_to_fpga_data_ready <= 1'b0;
            fpga_to_arm_data_valid <= 1'b0;
            fpga_to_arm_data       <= '0;
            core_op_ab             <= '0;
            core_op_m              <= '0;
            core_start             <= '0;
`ifdef MONT_CTRL_TIMEOUT_EN
            timeout                <= 1'b0;
            cnt                    <= '0;
`endif
        end else begin
            core_start <= '0;  // start is a single-cycle pulse
            case (state)
                IDLE: begin
                    if (arm_to_fpga_cmd_valid) begin
                        busy <= 1'b1;
                        case (opcode)
                            OP_RX_AB: begin
                                illegal                <= 1'b0;
                                arm_to_fpga_data_ready <= 1'b1;
                                state                  <= RX_AB;
                            end
                            OP_RX_M: begin
                                illegal                <= 1'b0;
                                arm_to_fpga_data_ready <= 1'b1;
                                state                  <= RX_M;
                            end
                            OP_START: begin
                                illegal <= 1'b0;
                                mask    <= cmd_mask;
                                flag    <= '0;
`ifdef MONT_CTRL_TIMEOUT_EN
                                timeout <= 1'b0;
`endif
                                if (cmd_mask != '0) begin
                                    core_start <= cmd_mask;
                                    state      <= START;
                                end else begin
                                    // nothing to launch: complete at once
                                    fpga_to_arm_done <= 1'b1;
                                    state            <= DONE;
                                end
                            end
                            OP_TX: begin
                                // latched here so the output stays stable
                                // for the whole handshake
                                illegal                <= 1'b0;
                                fpga_to_arm_data       <= sel_result;
                                fpga_to_arm_data_valid <= 1'b1;
                                state                  <= TX;
                            end
                            default: begin
                                illegal          <= 1'b1;
                                fpga_to_arm_done <= 1'b1;
                                state            <= DONE;
                            end
                        endcase
                    end
                end
                RX_AB: begin
                    if (arm_to_fpga_data_valid) begin
                        core_op_ab             <= arm_to_fpga_data;
                        arm_to_fpga_data_ready <= 1'b0;
                        fpga_to_arm_done       <= 1'b1;
                        state                  <= DONE;
                    end
                end
                RX_M: begin
                    if (arm_to_fpga_data_valid) begin
                        core_op_m              <= arm_to_fpga_data;
                        arm_to_fpga_data_ready <= 1'b0;
                        fpga_to_arm_done       <= 1'b1;
                        state                  <= DONE;
                    end
                end
                START: begin
                    // pulse cycle: core_done seen now is deliberately ignored
                    computing <= 1'b1;
                    state     <= COMPUTE;
`ifdef MONT_CTRL_TIMEOUT_EN
                    cnt       <= '0;
`endif
                end
                COMPUTE: begin
                    flag <= flag_next;
                    if (all_done) begin
                        computing        <= 1'b0;
                        fpga_to_arm_done <= 1'b1;
                        state            <= DONE;
                    end
`ifdef MONT_CTRL_TIMEOUT_EN
                    else if (cnt == CNT_LAST) begin
                        timeout          <= 1'b1;
                        computing        <= 1'b0;
                        fpga_to_arm_done <= 1'b1;
                        state            <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                TX: begin
                    if (fpga_to_arm_data_ready) begin
                        fpga_to_arm_data_valid <= 1'b0;
                        fpga_to_arm_done       <= 1'b1;
                        state                  <= DONE;
                    end
                end
                DONE: begin
                    if (fpga_to_arm_done_read) begin
                        fpga_to_arm_done <= 1'b0;
                        busy             <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_multicore_ctrl.sv
module tb_mont_multicore_ctrl;
    localparam int DW = 64;
    localparam int NC = 3;
    localparam int TO = 32;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [31:0]    cmd = '0;
    logic           cmd_valid = 1'b0;
    logic           done;
    logic           done_read = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [DW-1:0]  out_data;
    logic [DW-1:0]  op_ab, op_m;
    logic [NC-1:0]  core_start;
    logic [NC-1:0]  core_done = '0;
    logic [NC*DW-1:0] core_result = '0;
    logic [3:0]     leds;

    mont_multicore_ctrl #(.DATA_W(DW), .NUM_CORES(NC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .arm_to_fpga_cmd(cmd), .arm_to_fpga_cmd_valid(cmd_valid),
        .fpga_to_arm_done(done), .fpga_to_arm_done_read(done_read),
        .arm_to_fpga_data_valid(in_valid), .arm_to_fpga_data_ready(in_ready),
        .arm_to_fpga_data(in_data),
        .fpga_to_arm_data_valid(out_valid), .fpga_to_arm_data_ready(out_ready),
        .fpga_to_arm_data(out_data),
        .core_op_ab(op_ab), .core_op_m(op_m),
        .core_start(core_start), .core_done(core_done),
        .core_result(core_result), .leds(leds)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {{(DW-1){1'b0}}, act}, {{(DW-1){1'b0}}, exp});
    endtask

    task automatic chki(input string name, input int act, input int exp);
        chk(name, DW'(act), DW'(exp));
    endtask

    // ---------------- reference model state ----------------
    logic [DW-1:0] model_ab = '0;
    logic [DW-1:0] model_m  = '0;
    logic          model_ill = 1'b0;
    logic          model_tmo = 1'b0;
    logic [DW-1:0] res_m [NC];

    typedef struct {
        logic          ill;
        logic          tmo;
        logic [DW-1:0] ab;
        logic [DW-1:0] m;
        int            at;
    } done_exp_t;

    typedef struct {
        logic [NC-1:0] mask;
        int            at;
    } start_exp_t;

    done_exp_t     q_done[$];
    start_exp_t    q_start[$];
    logic [DW-1:0] q_data[$];

    // ---------------- monitor / scoreboard ----------------
    done_exp_t     mon_d;
    start_exp_t    mon_s;
    logic [DW-1:0] mon_x;
    logic          prev_done = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic          start_follow = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_done = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; start_follow = 1'b0;
        end else begin
            if (done && !prev_done) begin
                chkb("done_queued", q_done.size() > 0, 1'b1);
                if (q_done.size() > 0) begin
                    mon_d = q_done.pop_front();
                    chkb("done_led_illegal", leds[1], mon_d.ill);
                    chkb("done_led_timeout", leds[3], mon_d.tmo);
                    chkb("done_led_busy", leds[0], 1'b1);
                    chk("core_op_ab", op_ab, mon_d.ab);
                    chk("core_op_m", op_m, mon_d.m);
                    chki("done_cycle", cyc, mon_d.at);
                end
            end
            if (start_follow) chk("start_width", DW'(core_start), '0);
            start_follow = 1'b0;
            if (core_start != '0) begin
                start_follow = 1'b1;
                chkb("start_queued", q_start.size() > 0, 1'b1);
                if (q_start.size() > 0) begin
                    mon_s = q_start.pop_front();
                    chk("start_mask", DW'(core_start), DW'(mon_s.mask));
                    chki("start_cycle", cyc, mon_s.at);
                end
            end
            if (out_valid && prev_valid && !prev_ready) chk("tx_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                chkb("tx_queued", q_data.size() > 0, 1'b1);
                if (q_data.size() > 0) begin
                    mon_x = q_data.pop_front();
                    chk("tx_data", out_data, mon_x);
                end
            end
            prev_done = done; prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_results();
        for (int i = 0; i < NC; i++) core_result[i*DW +: DW] = res_m[i];
    endtask

    task automatic send_cmd(input logic [31:0] c, output int t0);
        @(posedge clk); #1;
        cmd = c; cmd_valid = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = $urandom;
    endtask

    task automatic finish_cmd(input bit pre);
        int n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        chkb("done_seen", done, 1'b1);
        if (done) begin
            if (pre) begin
                @(posedge clk); #1;
                chkb("done_one_cycle", done, 1'b0);
            end else begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                chkb("done_held", done, 1'b1);
                done_read = 1'b1;
                @(posedge clk); #1;
                done_read = 1'b0;
                chkb("done_cleared", done, 1'b0);
                chkb("idle_busy", leds[0], 1'b0);
            end
        end
        done_read = 1'b0;
    endtask

    task automatic rx(input logic [3:0] op, input logic [DW-1:0] d, input bit pre);
        int t0; logic [31:0] r; done_exp_t e;
        done_read = pre;
        r = $urandom;
        send_cmd({r[31:4], op}, t0);
        chkb("rx_ready_rise", in_ready, 1'b1);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        model_ill = 1'b0;
        if (op == 4'd1) model_ab = d; else model_m = d;
        e.ill = 1'b0; e.tmo = model_tmo; e.ab = model_ab; e.m = model_m; e.at = cyc + 1;
        q_done.push_back(e);
        in_valid = 1'b1; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = {$urandom, $urandom};
        finish_cmd(pre);
    endtask

    task automatic tx(input logic [7:0] idx, input bit pre, input bit spur);
        int t0; logic [31:0] r; done_exp_t e;
        done_read = pre;
        model_ill = 1'b0;
        if (idx < NC) q_data.push_back(res_m[idx]); else q_data.push_back('0);
        r = $urandom;
        send_cmd({r[31:24], idx, r[15:4], 4'h5}, t0);
        chkb("tx_valid_rise", out_valid, 1'b1);
        repeat ($urandom_range(0, 4)) begin
            if (spur) begin cmd_valid = 1'b1; cmd = 32'h0000_0001; end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        e.ill = 1'b0; e.tmo = model_tmo; e.ab = model_ab; e.m = model_m; e.at = cyc + 1;
        q_done.push_back(e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        finish_cmd(pre);
    endtask

    task automatic ill(input logic [3:0] op, input bit pre);
        int t0; logic [31:0] r; done_exp_t e;
        done_read = pre;
        model_ill = 1'b1;
        r = $urandom;
        send_cmd({r[31:4], op}, t0);
        e.ill = 1'b1; e.tmo = model_tmo; e.ab = model_ab; e.m = model_m; e.at = t0 + 1;
        q_done.push_back(e);
        finish_cmd(pre);
    endtask

    // del[i]: cycles after the command cycle at which core i pulses done
    // (0 = never; 1 = inside the start-pulse cycle, which must be ignored).
    // mode 0: normal, 1: expect watchdog completion, 2: no completion expected
    task automatic compute(input logic [7:0] mf, input int del [NC], input int mode);
        int t0, maxd, maxall; logic [31:0] r; logic [NC-1:0] m;
        done_exp_t e; start_exp_t s;
        m = mf[NC-1:0];
        model_tmo = 1'b0; model_ill = 1'b0;
        maxd = 0; maxall = 0;
        for (int i = 0; i < NC; i++) begin
            if (del[i] > maxall) maxall = del[i];
            if (m[i] && del[i] > maxd) maxd = del[i];
        end
        r = $urandom;
        send_cmd({r[31:16], mf, r[7:4], 4'h4}, t0);
        if (m != '0) begin s.mask = m; s.at = t0 + 1; q_start.push_back(s); end
        e.ill = 1'b0; e.tmo = 1'b0; e.ab = model_ab; e.m = model_m;
        if (m == '0)       e.at = t0 + 1;
        else if (mode == 1) begin e.tmo = 1'b1; e.at = t0 + 2 + TO; end
        else               e.at = t0 + maxd + 1;
        if (mode != 2) q_done.push_back(e);
        if (mode == 1) model_tmo = 1'b1;
        while (cyc - t0 <= maxall) begin
            for (int i = 0; i < NC; i++) core_done[i] = (del[i] == cyc - t0);
            @(posedge clk); #1;
        end
        core_done = '0;
        if (mode != 2) finish_cmd(1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chkb({tag, "_done"}, done, 1'b0);
        chkb({tag, "_ready"}, in_ready, 1'b0);
        chkb({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_start"}, DW'(core_start), '0);
        chk({tag, "_leds"}, DW'(leds), '0);
        chk({tag, "_op_ab"}, op_ab, '0);
        chk({tag, "_op_m"}, op_m, '0);
        chk({tag, "_data"}, out_data, '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int d [NC];
        int seen;
        int sel;
        for (int i = 0; i < NC; i++) res_m[i] = {$urandom, $urandom};
        res_m[1] = 64'hABCD;
        load_results();

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        resetn = 1'b1;

        // operand loads
        rx(4'd1, 64'h1234, 1'b0);
        rx(4'd2, 64'hF00D, 1'b1);

        // two-core launch; core2 unmasked and its done ignored
        d = '{10, 25, 7};
        compute(8'h03, d, 0);

        // readback, including out-of-range indices and ignored mid-TX commands
        tx(8'd1, 1'b0, 1'b1);
        tx(8'd0, 1'b1, 1'b0);
        tx(8'd2, 1'b0, 1'b1);
        tx(8'd3, 1'b0, 1'b0);
        tx(8'hFF, 1'b1, 1'b0);

        // reserved opcodes; legal command clears the flag
        ill(4'h7, 1'b0);
        rx(4'd1, 64'h5555_AAAA_0123_4567, 1'b0);
        ill(4'h0, 1'b1);
        ill(4'h3, 1'b0);
        ill(4'hF, 1'b1);
        tx(8'd1, 1'b0, 1'b0);

        // mask bits above NUM_CORES discarded -> empty mask, no pulse
        d = '{2, 30, 2};
        compute(8'hF8, d, 0);
        d = '{5, 9, 14};
        compute(8'hFF, d, 0);
        d = '{12, 3, 6};
        compute(8'h05, d, 0);

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: rx(4'($urandom_range(1, 2)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
                1: begin
                    for (int i = 0; i < NC; i++) res_m[i] = {$urandom, $urandom};
                    load_results();
                    tx(8'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                2: begin
                    for (int i = 0; i < NC; i++) d[i] = $urandom_range(2, 20);
                    compute(8'($urandom), d, 0);
                end
                default: begin
                    sel = $urandom_range(0, 11);
                    ill((sel == 0) ? 4'h0 : (sel == 1) ? 4'h3 : 4'(sel + 4), 1'($urandom_range(0, 1)));
                end
            endcase
        end

        // core0 reports only in the start-pulse cycle, so it never completes
        d = '{1, 0, 0};
`ifdef MONT_CTRL_TIMEOUT_EN
        compute(8'h01, d, 1);
        d = '{0, 1, 0};
        compute(8'h02, d, 2);
        repeat (5) begin @(posedge clk); #1; end
`else
        compute(8'h01, d, 2);
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chki("hang_no_done", seen, 0);
        @(posedge clk); #1;
`endif
        chkb("computing_led", leds[2], 1'b1);

        // asynchronous reset in the middle of COMPUTE
        resetn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        q_done.delete(); q_start.delete(); q_data.delete();
        model_ab = '0; model_m = '0; model_ill = 1'b0; model_tmo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        rx(4'd1, 64'hC0FF_EE00_1234_5678, 1'b0);
        d = '{4, 6, 3};
        compute(8'h07, d, 0);
        tx(8'd1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chki("queues_drained", q_done.size() + q_start.size() + q_data.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
